// File: rtl/hamming_enc_stream.sv
// Streaming Hamming(12,8) encoder with optional single-bit error injection,
// buffered in a 2-entry FIFO with valid/ready handshakes on both sides.
module hamming_enc_stream (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:8]  in_data,
    input  logic        inj_en,
    input  logic [3:0]  inj_pos,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:12] out_code,
    output logic [15:0] word_count,
    output logic [7:0]  inj_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    // Even-parity Hamming(12,8); vector index equals codeword position.
    function automatic logic [1:12] hamming_encode(input logic [1:8] d);
        logic [1:12] c;
        c     = 12'h000;
        c[3]  = d[1];
        c[5]  = d[2];
        c[6]  = d[3];
        c[7]  = d[4];
        c[9]  = d[5];
        c[10] = d[6];
        c[11] = d[7];
        c[12] = d[8];
        c[1]  = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11];
        c[2]  = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
        c[4]  = c[5] ^ c[6] ^ c[7] ^ c[12];
        c[8]  = c[9] ^ c[10] ^ c[11] ^ c[12];
        return c;
    endfunction

    occ_t        state_r;
    occ_t        state_nx_s;
    logic [1:12] mem_r [0:1];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [15:0] word_count_r;
    logic [7:0]  inj_count_r;
    logic        push_s;
    logic        pop_s;
    logic        inj_valid_s;
    logic [1:12] inj_mask_s;
    logic [1:12] enc_s;

    assign in_ready   = ~rst && (state_r != FULL);
    assign out_valid  = (state_r != EMPTY);
    assign push_s     = in_valid && in_ready;
    assign pop_s      = out_valid && out_ready;
    assign word_count = word_count_r;
    assign inj_count  = inj_count_r;

    // Encode the incoming byte and apply the requested bit flip after parity.
    always_comb begin
        inj_valid_s = inj_en && (inj_pos >= 4'd1) && (inj_pos <= 4'd12);
        if (inj_valid_s) begin
            inj_mask_s = 12'h800 >> (inj_pos - 4'd1);
        end else begin
            inj_mask_s = 12'h000;
        end
        enc_s = hamming_encode(in_data) ^ inj_mask_s;
    end

    // Head of the FIFO; forced to zero while nothing is stored.
    always_comb begin
        if (out_valid) begin
            out_code = mem_r[rd_ptr_r];
        end else begin
            out_code = 12'h000;
        end
    end

    // Occupancy next-state.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            EMPTY: begin
                if (push_s) state_nx_s = ONE;
                else        state_nx_s = EMPTY;
            end
            ONE: begin
                if (push_s && !pop_s)      state_nx_s = FULL;
                else if (pop_s && !push_s) state_nx_s = EMPTY;
                else                       state_nx_s = ONE;
            end
            FULL: begin
                if (pop_s) state_nx_s = ONE;
                else       state_nx_s = FULL;
            end
            default: state_nx_s = EMPTY;
        endcase
    end

    // State, storage, pointers and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= EMPTY;
            wr_ptr_r     <= 1'b0;
            rd_ptr_r     <= 1'b0;
            mem_r[0]     <= 12'h000;
            mem_r[1]     <= 12'h000;
            word_count_r <= 16'h0000;
            inj_count_r  <= 8'h00;
        end else begin
            state_r <= state_nx_s;
            if (push_s) begin
                mem_r[wr_ptr_r] <= enc_s;
                wr_ptr_r        <= ~wr_ptr_r;
                if (inj_valid_s && (inj_count_r != 8'hFF)) begin
                    inj_count_r <= inj_count_r + 8'd1;
                end
            end
            if (pop_s) begin
                rd_ptr_r     <= ~rd_ptr_r;
                word_count_r <= word_count_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_enc_stream.sv
// Scoreboard bench for hamming_enc_stream: expected codewords are queued on
// acceptance and compared when the sink pops them.
module tb_hamming_enc_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        inj_en;
    logic [3:0]  inj_pos;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_code;
    logic [15:0] word_count;
    logic [7:0]  inj_count;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    logic [7:0]  in_q[$];
    int          exp_wc;
    int          exp_ic;
    logic        last_acc;

    always #5 clk = ~clk;

    hamming_enc_stream dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .inj_en(inj_en), .inj_pos(inj_pos),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .word_count(word_count), .inj_count(inj_count)
    );

    // Reference: parity bit p covers every position whose index has bit p set.
    function automatic logic [11:0] model_enc(input logic [7:0] d, input logic en, input logic [3:0] pos);
        logic [11:0] r;
        logic        par;
        int          j;
        r = 12'h000;
        j = 7;
        for (int k = 1; k <= 12; k++) begin
            if ((k & (k - 1)) != 0) begin
                r[12-k] = d[j];
                j--;
            end
        end
        for (int p = 1; p <= 8; p = p * 2) begin
            par = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                if (((k & p) != 0) && (k != p)) par ^= r[12-k];
            end
            r[12-p] = par;
        end
        if (en && (pos >= 4'd1) && (pos <= 4'd12)) r[12-pos] = ~r[12-pos];
        return r;
    endfunction

    // Decoder returning {syndrome, data}.
    function automatic logic [11:0] model_dec(input logic [11:0] c);
        logic [3:0] syn;
        logic [7:0] d;
        int         j;
        syn = 4'd0;
        d   = 8'h00;
        j   = 7;
        for (int k = 1; k <= 12; k++) begin
            if (c[12-k]) syn ^= k[3:0];
            if ((k & (k - 1)) != 0) begin
                d[j] = c[12-k];
                j--;
            end
        end
        return {syn, d};
    endfunction

    // One clock: record handshakes just after inputs settle, end on the next falling edge.
    task automatic tick;
        #1;
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            exp_q.push_back(model_enc(in_data, inj_en, inj_pos));
            in_q.push_back(in_data);
            if (inj_en && (inj_pos >= 4'd1) && (inj_pos <= 4'd12) && (exp_ic < 255)) exp_ic++;
        end
        if (out_valid && out_ready) begin
            obs_q.push_back(out_code);
            exp_wc = (exp_wc + 1) % 65536;
        end
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inj_en = 1'b0; inj_pos = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); obs_q.delete(); in_q.delete();
        exp_wc = 0; exp_ic = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete(); obs_q.delete(); in_q.delete(); exp_wc = 0; exp_ic = 0;
        #1;
        tests_run++;
        if ({out_valid, out_code, word_count, inj_count, in_ready} !== {1'b0, 12'h000, 16'h0000, 8'h00, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b code=%h wc=%h ic=%h rdy=%b expected v=0 code=000 wc=0000 ic=00 rdy=1",
                     out_valid, out_code, word_count, inj_count, in_ready);
        end
    endtask

    task automatic test_basic;
        do_reset();
        out_ready = 1'b1; in_data = 8'hB2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_code !== 12'hA72) begin
            tests_failed++; $display("FAIL basic_code: got v=%b %h expected v=1 a72", out_valid, out_code);
        end
        tick();
        #1;
        tests_run++;
        if (word_count !== 16'd1 || out_valid !== 1'b0 || out_code !== 12'h000) begin
            tests_failed++; $display("FAIL basic_after: got wc=%0d v=%b code=%h expected wc=1 v=0 code=000", word_count, out_valid, out_code);
        end
        while (obs_q.size() > 0) begin
            logic [11:0] got, exp;
            got = obs_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL basic_sb: got %h expected %h", got, exp); end
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h00;
        tick();
        in_data = 8'hFF;
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_code !== 12'h000) begin
            tests_failed++; $display("FAIL b2b_first: got v=%b %h expected v=1 000", out_valid, out_code);
        end
        tick();
        tests_run++;
        if (last_acc !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept: got %b expected 1", last_acc); end
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_code !== 12'hEEF) begin
            tests_failed++; $display("FAIL b2b_second: got v=%b %h expected v=1 eef", out_valid, out_code);
        end
        tick();
        tick();
        while (obs_q.size() > 0) begin
            logic [11:0] got, exp;
            got = obs_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL b2b_sb: got %h expected %h", got, exp); end
        end
        tests_run++;
        if (word_count !== 16'd2) begin tests_failed++; $display("FAIL b2b_wc: got %0d expected 2", word_count); end
    endtask

    task automatic test_inject;
        logic [3:0]  pos_t [4] = '{4'd5, 4'd0, 4'd12, 4'd13};
        logic [11:0] code_t[4] = '{12'hAF2, 12'hA72, 12'hA73, 12'hA72};
        logic [7:0]  ic_t  [4] = '{8'd1, 8'd1, 8'd2, 8'd2};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hB2; inj_en = 1'b1; inj_pos = pos_t[i]; in_valid = 1'b1;
            tick();
            in_valid = 1'b0; inj_en = 1'b0; inj_pos = 4'd7;
            #1;
            tests_run++;
            if (out_code !== code_t[i] || inj_count !== ic_t[i]) begin
                tests_failed++;
                $display("FAIL inject_pos%0d: got code=%h ic=%0d expected code=%h ic=%0d", pos_t[i], out_code, inj_count, code_t[i], ic_t[i]);
            end
            tick();
        end
        while (obs_q.size() > 0) begin
            logic [11:0] got, exp;
            got = obs_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL inject_sb: got %h expected %h", got, exp); end
        end
    endtask

    task automatic test_full;
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        in_data = 8'h33;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        tick();
        tests_run++;
        if (last_acc !== 1'b0 || exp_q.size() != 2) begin
            tests_failed++; $display("FAIL full_third: got acc=%b depth=%0d expected acc=0 depth=2", last_acc, exp_q.size());
        end
        tests_run++;
        if (out_code !== model_enc(8'h11, 1'b0, 4'd0)) begin
            tests_failed++; $display("FAIL full_hold: got %h expected %h", out_code, model_enc(8'h11, 1'b0, 4'd0));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        while (obs_q.size() > 0) begin
            logic [11:0] got, exp;
            got = obs_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL full_order: got %h expected %h", got, exp); end
        end
        tests_run++;
        if (word_count !== 16'd2 || exp_q.size() != 0) begin
            tests_failed++; $display("FAIL full_wc: got wc=%0d left=%0d expected wc=2 left=0", word_count, exp_q.size());
        end
    endtask

    task automatic test_reset_full;
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h3C; inj_en = 1'b1; inj_pos = 4'd3;
        tick();
        out_ready = 1'b0; in_data = 8'hC3;
        tick();
        tick();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; inj_en = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rfull_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete(); obs_q.delete(); in_q.delete(); exp_wc = 0; exp_ic = 0;
        #1;
        tests_run++;
        if ({out_valid, in_ready, out_code, word_count, inj_count} !== {1'b0, 1'b1, 12'h000, 16'h0000, 8'h00}) begin
            tests_failed++;
            $display("FAIL rfull_state: got v=%b rdy=%b code=%h wc=%h ic=%h expected v=0 rdy=1 code=000 wc=0000 ic=00",
                     out_valid, in_ready, out_code, word_count, inj_count);
        end
    endtask

    task automatic test_inj_saturate;
        int guard;
        do_reset();
        out_ready = 1'b1; inj_en = 1'b1;
        for (int i = 0; i < 320; i++) begin
            in_data = 8'($urandom); inj_pos = 4'((i % 14) + 1); in_valid = 1'b1;
            guard = 0;
            do begin tick(); guard++; end while (!last_acc && guard < 10);
            if (!last_acc) begin tests_run++; tests_failed++; $display("FAIL sat_accept: got timeout expected accept at word %0d", i); end
        end
        in_valid = 1'b0; inj_en = 1'b0;
        tick(); tick();
        while (obs_q.size() > 0) begin
            logic [11:0] got, exp;
            got = obs_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL sat_sb: got %h expected %h", got, exp); end
        end
        tests_run++;
        if (inj_count !== 8'(exp_ic) || inj_count !== 8'hFF) begin
            tests_failed++; $display("FAIL sat_ic: got %0d expected %0d (255)", inj_count, exp_ic);
        end
        tests_run++;
        if (word_count !== 16'(exp_wc)) begin tests_failed++; $display("FAIL sat_wc: got %0d expected %0d", word_count, exp_wc); end
    endtask

    task automatic test_all_bytes;
        int guard;
        logic [11:0] dec;
        do_reset();
        for (int b = 0; b < 256; b++) begin
            in_data = 8'(b); in_valid = 1'b1; inj_en = 1'b0;
            guard = 0;
            do begin out_ready = ($urandom_range(0, 3) != 0); tick(); guard++; end while (!last_acc && guard < 40);
            if (!last_acc) begin tests_run++; tests_failed++; $display("FAIL all_accept: got timeout expected accept byte %0d", b); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        while (obs_q.size() > 0) begin
            logic [11:0] got, exp;
            logic [7:0]  src;
            got = obs_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            src = (in_q.size() > 0) ? in_q.pop_front() : 8'hxx;
            dec = model_dec(got);
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL all_code: got %h expected %h", got, exp); end
            tests_run++;
            if (dec !== {4'd0, src}) begin
                tests_failed++; $display("FAIL all_decode: got syn=%h data=%h expected syn=0 data=%h", dec[11:8], dec[7:0], src);
            end
        end
        tests_run++;
        if (word_count !== 16'd256) begin tests_failed++; $display("FAIL all_wc: got %0d expected 256", word_count); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; inj_en = 1'b0; inj_pos = 4'd0; out_ready = 1'b0;
        exp_wc = 0; exp_ic = 0; last_acc = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_inject();
        test_full();
        test_reset_full();
        test_inj_saturate();
        test_all_bytes();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
